pll_lock_monitor: RTL and testbench

Sits between the PLL clock output and the RVMyth core's reset input. It runs on the PLL output clock and measures how many clk cycles fit in each REF period. It declares lock after a run of in-tolerance periods and holds the core in reset until lock is reached. It also drops lock and re-asserts core reset after a run of out-of-tolerance or missing REF periods.

---
 rtl/pll_lock_monitor.sv | 126 ++++++++++++
 tb/tb_pll_lock_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_monitor.sv
// rtl/pll_lock_monitor.sv - PLL lock monitor: counts clk cycles per REF period, gates core reset on lock
module pll_lock_monitor #(
    parameter int RATIO      = 8,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ref_in,
    input  logic             en_vco,
    output logic             locked,
    output logic             core_reset,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             lock_lost
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam logic [CNT_W-1:0] LO       = CNT_W'((RATIO > TOL) ? RATIO - TOL : 0);
    localparam logic [CNT_W-1:0] HI       = CNT_W'(RATIO + TOL);
    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
    localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_CNT);
    localparam logic [BW-1:0]    BAD_MAX  = BW'(UNLOCK_CNT);

    typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, LOCKED} state_t;

    state_t           state, state_nx;
    logic             s1, s2, prev;
    logic [CNT_W-1:0] cnt, cnt_nx, period_nx;
    logic [GW-1:0]    good_cnt, good_nx;
    logic [BW-1:0]    bad_cnt, bad_nx;
    logic             pv_nx;
    logic             rise, timeout, good_win;

    assign rise     = s2 & ~prev;
    assign timeout  = (cnt == TMO);
    assign good_win = rise && (cnt >= LO) && (cnt <= HI);

    // core_reset is combinational from reset so the core is held even in the reset cycle
    assign core_reset = reset | ~locked;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= ref_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            good_cnt     <= good_nx;
            bad_cnt      <= bad_nx;
            period       <= period_nx;
            period_valid <= pv_nx;
            locked       <= (state_nx == LOCKED);
            lock_lost    <= (state == LOCKED) && (state_nx != LOCKED);
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        good_nx   = good_cnt;
        bad_nx    = bad_cnt;
        period_nx = period;
        pv_nx     = 1'b0;
        if (!en_vco) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            good_nx  = '0;
            bad_nx   = '0;
        end else begin
            case (state)
                IDLE: state_nx = ACQUIRE;
                ACQUIRE: begin
                    // the window in progress when enabled is partial, so it is never measured
                    if (rise) begin
                        cnt_nx   = CNT_W'(1);
                        state_nx = MEASURE;
                    end
                end
                default: begin
                    if (rise || timeout) begin
                        pv_nx     = 1'b1;
                        cnt_nx    = CNT_W'(1);
                        period_nx = rise ? cnt : TMO;
                        if (good_win) begin
                            good_nx = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + 1'b1;
                            bad_nx  = '0;
                            if (state == MEASURE && good_nx == GOOD_MAX)
                                state_nx = LOCKED;
                        end else begin
                            bad_nx  = (bad_cnt == BAD_MAX) ? bad_cnt : bad_cnt + 1'b1;
                            good_nx = '0;
                            if (state == LOCKED && bad_nx == BAD_MAX)
                                state_nx = MEASURE;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb/tb_pll_lock_monitor.sv - scoreboard bench for pll_lock_monitor
module tb_pll_lock_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       ref_in;
    logic       en_vco;
    logic       locked;
    logic       core_reset;
    logic [7:0] period;
    logic       period_valid;
    logic       lock_lost;

    int n_checks = 0;
    int n_pass   = 0;
    int sb[$];
    int gap      = 0;
    bit acq      = 1'b1;
    int pv_seen  = 0;
    int lost_cnt = 0;
    int pv_snap;

    pll_lock_monitor dut (
        .clk          (clk),
        .reset        (reset),
        .ref_in       (ref_in),
        .en_vco       (en_vco),
        .locked       (locked),
        .core_reset   (core_reset),
        .period       (period),
        .period_valid (period_valid),
        .lock_lost    (lock_lost)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (period_valid) begin
            pv_seen++;
            if (sb.size() == 0) check_eq("pv_unexpected", 32'd1, 32'd0);
            else check_eq("period", {24'd0, period}, sb.pop_front());
        end
        if (lock_lost) lost_cnt++;
    end

    // One REF rising edge followed by p clk cycles; the edge measures the previous gap.
    task automatic pulse(input int p, input bit probe, input bit lk_before);
        if (acq) acq = 1'b0;
        else sb.push_back(gap);
        ref_in = 1'b1;
        for (int i = 0; i < p; i++) begin
            @(negedge clk);
            if (i == p / 2 - 1) ref_in = 1'b0;
            if (probe && i == 1) check_eq("lock_before", locked, lk_before);
            if (probe && i == 2) begin
                check_eq("lock_after", locked, !lk_before);
                check_eq("core_reset_after", core_reset, lk_before);
                check_eq("lock_lost_edge", lock_lost, lk_before);
            end
            if (probe && i == 3) check_eq("lock_lost_1cyc", lock_lost, 0);
        end
        gap = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        en_vco = 1'b0;
        ref_in = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_core_reset", core_reset, 1);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_period", period, 0);
        check_eq("rst_pv", period_valid, 0);
        check_eq("rst_lock_lost", lock_lost, 0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_core_reset", core_reset, 1);

        // T1: nominal 8-cycle REF, lock after ACQUIRE rise plus 4 good windows
        en_vco = 1'b1;
        @(negedge clk);
        acq = 1'b1;
        repeat (4) pulse(8, 1'b0, 1'b0);
        check_eq("t1_not_yet", locked, 0);
        pulse(8, 1'b1, 1'b0);
        check_eq("t1_period", period, 8);

        // reset mid-operation
        reset = 1'b1;
        #1;
        check_eq("midrst_core_reset_comb", core_reset, 1);
        @(negedge clk);
        check_eq("midrst_locked", locked, 0);
        check_eq("midrst_period", period, 0);
        reset = 1'b0;
        acq   = 1'b1;

        // T2: a 10 in the middle restarts the good run
        pulse(8, 1'b0, 1'b0);
        pulse(8, 1'b0, 1'b0);
        pulse(10, 1'b0, 1'b0);
        pulse(8, 1'b0, 1'b0);
        pulse(8, 1'b0, 1'b0);
        pulse(8, 1'b0, 1'b0);
        pulse(8, 1'b0, 1'b0);
        check_eq("t2_no_lock_after_bad", locked, 0);
        pulse(8, 1'b1, 1'b0);

        // T3: single bad window tolerated, two consecutive drop lock
        pulse(6, 1'b0, 1'b0);
        pulse(8, 1'b0, 1'b0);
        pulse(8, 1'b0, 1'b0);
        check_eq("t3_single_bad", locked, 1);
        pulse(6, 1'b0, 1'b0);
        pulse(6, 1'b0, 1'b0);
        check_eq("t3_one_bad_again", locked, 1);
        pulse(8, 1'b1, 1'b1);
        check_eq("t3_lost_cnt", lost_cnt, 1);

        // T4: relock, then REF stops and two timeouts drop lock
        repeat (3) pulse(8, 1'b0, 1'b0);
        pulse(8, 1'b1, 1'b0);
        sb.push_back(31);
        sb.push_back(31);
        repeat (40) @(negedge clk);
        check_eq("t4_after_first_timeout", locked, 1);
        check_eq("t4_one_timeout_seen", sb.size(), 1);
        repeat (20) @(negedge clk);
        check_eq("t4_after_second_timeout", locked, 0);
        check_eq("t4_lost_cnt", lost_cnt, 2);
        check_eq("t4_period", period, 31);

        // T5: relock with 7/9 periods, then en_vco drop while locked
        en_vco = 1'b0;
        @(negedge clk);
        en_vco = 1'b1;
        acq    = 1'b1;
        pulse(7, 1'b0, 1'b0);
        pulse(9, 1'b0, 1'b0);
        pulse(7, 1'b0, 1'b0);
        pulse(9, 1'b0, 1'b0);
        pulse(8, 1'b1, 1'b0);
        en_vco = 1'b0;
        @(negedge clk);
        check_eq("t5_drop_locked", locked, 0);
        check_eq("t5_drop_core_reset", core_reset, 1);
        check_eq("t5_drop_lock_lost", lock_lost, 1);
        check_eq("t5_period_hold", period, 9);
        en_vco = 1'b1;
        acq    = 1'b1;
        repeat (4) pulse(8, 1'b0, 1'b0);
        check_eq("t5_relock_pending", locked, 0);
        check_eq("t5_lost_cnt", lost_cnt, 3);
        pulse(8, 1'b1, 1'b0);

        // T6: sub-cycle glitches while idle
        en_vco = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pv_snap = pv_seen;
        repeat (20) begin
            @(negedge clk);
            #1 ref_in = 1'b1;
            #2 ref_in = 1'b0;
        end
        repeat (4) @(negedge clk);
        check_eq("t6_no_pv", pv_seen, pv_snap);
        check_eq("t6_locked", locked, 0);
        check_eq("t6_core_reset", core_reset, 1);
        check_eq("t6_period_hold", period, 8);
        check_eq("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
